pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Arbitrates per-stage stall requests and exception/ERET requests.
- Drives the stall/flush pair of every inter-stage register, including the EX/MEM register.
- Sequences the PC redirect after a flush and watches for stuck stalls.

Parameters:
- NSTAGE, 5: number of stages; stall/flush vector width.
- EXC_STAGE, 3: stage index that raises exceptions (MEM).
- TMO_W, 16: width of the stall watchdog counter.
- STALL_TMO, 16'hFFFF: consecutive stalled cycles that trip the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stallreq  in  NSTAGE  bit i=1: stage i cannot complete this cycle.
- exc_req  in  1  exception taken in stage EXC_STAGE (combinational, same cycle).
- exc_target  in  32  exception vector address.
- eret_req  in  1  ERET committing in stage EXC_STAGE.
- epc  in  32  return address for ERET.
- stall  out  NSTAGE  bit i=1: register at input of stage i holds.
- flush  out  NSTAGE  bit i=1: register at input of stage i loads a bubble (overrides stall).
- redirect_valid  out  1  IF must load redirect_pc.
- redirect_pc  out  32  redirect address.
- stall_timeout  out  1  sticky watchdog flag.
- perf_stall_cyc  out  32  stalled-cycle count (optional feature).
- perf_flush_cnt  out  32  flush event count (optional feature).

Behaviour:
- rst is asynchronous, active-high; clk is the clock.
- Reset values: state=RUN, stall=0, flush=0, redirect_valid=0, redirect_pc=0, stall_timeout=0, watchdog=0, perf counters=0.
- stall and flush are combinational from state and inputs; everything else is registered.
- Stall rule: k = highest i with stallreq[i]=1.
  - stall[0..k]=1.
  - flush[k+1]=1 if k+1<NSTAGE, to insert a bubble downstream.
  - All other bits 0.
  - No request: all 0.
- States: RUN, REDIR.
- RUN, exc_req|eret_req=1:
  - flush[i]=1 for i<=EXC_STAGE+1, capped at NSTAGE-1; stall=0.
  - The stallreq rule is ignored that cycle.
  - Latch redirect_pc = exc_target if exc_req, else epc; exc_req has priority over eret_req.
  - Next state REDIR.
- REDIR:
  - redirect_valid=1; redirect_pc held.
  - stall/flush follow the stall rule.
  - exc_req and eret_req are ignored, since the pipeline is empty.
  - Exit to RUN after the first cycle with stall[0]=0, when IF accepts the redirect.
  - redirect_valid falls on the clock edge that enters RUN.
- Watchdog:
  - Increments each cycle with any stall bit=1; clears on a cycle with no stall.
  - Saturates at STALL_TMO.
  - On reaching STALL_TMO, stall_timeout sets and stays set until rst.
- Reset mid-REDIR: returns to RUN immediately with redirect_valid=0.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined:
  - perf_stall_cyc increments each cycle any stall bit=1.
  - perf_flush_cnt increments on each RUN→REDIR transition.
  - Both wrap at 2^32.
- Undefined: both ports tied to 0 and no counter flops are instantiated.

Test Plan:
- stallreq=5'b00100 for 3 cycles in RUN -> stall=5'b00111 and flush=5'b01000 each cycle, then 0; watchdog returns to 0.
- exc_req=1, exc_target=32'hBFC00380 with stallreq=5'b00010 -> same cycle flush=5'b11111, stall=0; next cycle redirect_valid=1, redirect_pc=32'hBFC00380, for exactly one cycle.
- exc_req=1 and eret_req=1 simultaneously, epc=32'h80001000 -> redirect_pc=exc_target; a second exc_req during REDIR is ignored.
- Enter REDIR with stallreq[0]=1 for 4 cycles -> redirect_valid held 5 cycles and stall[0]=1 for 4 of them; RUN entered after the first cycle with stall[0]=0.
- STALL_TMO=16'd8 with stallreq[1] held -> stall_timeout rises after cycle 8 and stays high after the stall clears; rst clears it.
- PIPE_PERF_CNT_EN defined: 10 stalled cycles + 2 exceptions -> perf_stall_cyc=10, perf_flush_cnt=2; rst asserted mid-REDIR -> all counters 0 and state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush arbitration, exception/ERET redirect and stall watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
`timescale 1ns/1ps
module pipe_ctrl #(
  parameter int unsigned NSTAGE    = 5,
  parameter int unsigned EXC_STAGE = 3,
  parameter int unsigned TMO_W     = 16,
  parameter logic [TMO_W-1:0] STALL_TMO = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              exc_req,
  input  logic [31:0]       exc_target,
  input  logic              eret_req,
  input  logic [31:0]       epc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              stall_timeout,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt
);

  typedef enum logic [0:0] {StRun, StRedir} state_e;

  state_e            state_q, state_d;
  logic [31:0]       rpc_q, rpc_d;
  logic              rv_q;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic              tmo_q, tmo_d;
  logic [NSTAGE-1:0] rule_stall, rule_flush, exc_flush;
  logic              above;
  logic              take_exc;
  logic              any_stall;

  // A stage stalls when it or any downstream stage requests; the stage just
  // below the highest requester receives a bubble.
  always_comb begin
    rule_stall = '0;
    rule_flush = '0;
    exc_flush  = '0;
    above      = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      above         = above | stallreq[i];
      rule_stall[i] = above;
      exc_flush[i]  = (i <= int'(EXC_STAGE) + 1);
    end
    for (int i = 1; i < NSTAGE; i++) begin
      rule_flush[i] = stallreq[i-1] & ~rule_stall[i];
    end
  end

  assign take_exc = (state_q == StRun) && (exc_req || eret_req);

  always_comb begin
    stall   = rule_stall;
    flush   = rule_flush;
    state_d = state_q;
    rpc_d   = rpc_q;
    unique case (state_q)
      StRun: begin
        if (take_exc) begin
          stall   = '0;
          flush   = exc_flush;
          state_d = StRedir;
          rpc_d   = exc_req ? exc_target : epc;
        end
      end
      StRedir: begin
        // Leave once IF is free to accept the redirect address.
        if (!rule_stall[0]) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign any_stall = |stall;

  always_comb begin
    wdog_d = '0;
    if (any_stall) wdog_d = (wdog_q == STALL_TMO) ? wdog_q : wdog_q + 1'b1;
    tmo_d = tmo_q | (any_stall && (wdog_d == STALL_TMO));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      rpc_q   <= '0;
      rv_q    <= 1'b0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      rv_q    <= (state_d == StRedir);
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign stall_timeout  = tmo_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] pstall_q, pflush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      if (any_stall) pstall_q <= pstall_q + 32'd1;
      if (take_exc)  pflush_q <= pflush_q + 32'd1;
    end
  end

  assign perf_stall_cyc = pstall_q;
  assign perf_flush_cnt = pflush_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
